// File: rtl/alu_cmd_issuer_pkg.sv
// Shared ALU widths and opcodes for the command issuer and alu_4bits.
package alu_cmd_issuer_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_SEL_W  = 2;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_OP_ADD = 2'b00,
    ALU_OP_SUB = 2'b01,
    ALU_OP_AND = 2'b10,
    ALU_OP_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_4bits.sv
// Combinational 4-bit ALU fed by alu_cmd_issuer.
module alu_4bits
  import alu_cmd_issuer_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  input  logic [ALU_SEL_W-1:0]  sel,
  output logic [ALU_DATA_W-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  logic [ALU_DATA_W:0] ext;

  always_comb begin
    ext = '0;
    case (alu_op_e'(sel))
      ALU_OP_ADD: ext = {1'b0, a} + {1'b0, b};
      ALU_OP_SUB: ext = {1'b0, a} - {1'b0, b};
      ALU_OP_AND: ext = {1'b0, a & b};
      ALU_OP_OR:  ext = {1'b0, a | b};
      default:    ext = '0;
    endcase
  end

  assign result = ext[ALU_DATA_W-1:0];
  assign carry  = ext[ALU_DATA_W];
  assign zero   = (result == '0);

endmodule

// File: rtl/alu_cmd_issuer_fifo.sv
// In-order command FIFO; clr wipes pointers and level in one edge.
module alu_cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) level_d = level_q + 1'b1;
      if (pop && !push) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands and issues at most one per clock
// through a registered a/b/sel slot.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     issue_ready,
  output logic                     issue_valid,
  output logic [DATA_W-1:0]        a,
  output logic [DATA_W-1:0]        b,
  output logic [SEL_W-1:0]         sel,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = 2 * DATA_W + SEL_W;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [CW-1:0] wdata, rdata;
  logic          full, empty;
  logic          push, pop;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;

  // Flush wins over both sides; the dropped push still sees ready.
  assign in_ready = flush | ~full;
  assign push     = in_valid & ~full & ~flush;
  assign pop      = issue_ready & ~empty & ~flush;
  assign wdata    = {in_a, in_b, in_sel};

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH),
    .AW    ($clog2(DEPTH)),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    valid_d = pop;
    if (pop) {a_d, b_d, sel_d} = rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign sel         = sel_q;
  assign issue_valid = valid_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench: issuer driving alu_4bits, table rows plus
// hand sequences for wrap, flush and mid-run reset.
module tb_alu_cmd_issuer;

  logic       clk, rst_n, flush, in_valid, in_ready;
  logic [3:0] in_a, in_b, a, b, result;
  logic [1:0] in_sel, sel;
  logic       issue_ready, issue_valid, carry, zero;
  logic [2:0] level;

  int n_chk = 0;
  int n_pass = 0;

  alu_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .issue_ready(issue_ready), .issue_valid(issue_valid),
    .a(a), .b(b), .sel(sel), .level(level)
  );

  alu_4bits u_alu (
    .a(a), .b(b), .sel(sel),
    .result(result), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] ia, ib;
    logic [1:0] is;
    logic       ir, fl;
    logic       ev;
    logic [3:0] ea, eb;
    logic [1:0] es;
    logic [2:0] el;
    logic       erdy;
    logic [3:0] eres;
    logic       ec, ez;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic row(input logic iv, input int ia, input int ib,
                     input int is, input logic ir, input logic ev,
                     input int ea, input int eb, input int es,
                     input int el, input logic erdy, input int eres,
                     input logic ec, input logic ez);
    vec_t v;
    v.iv = iv; v.ia = 4'(ia); v.ib = 4'(ib); v.is = 2'(is);
    v.ir = ir; v.fl = 1'b0; v.ev = ev;
    v.ea = 4'(ea); v.eb = 4'(eb); v.es = 2'(es);
    v.el = 3'(el); v.erdy = erdy; v.eres = 4'(eres);
    v.ec = ec; v.ez = ez;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input int ia, input int ib,
                       input int is, input logic ir, input logic fl);
    in_valid = iv; in_a = 4'(ia); in_b = 4'(ib);
    in_sel = 2'(is); issue_ready = ir; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_q[$];
    int issued;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iv", issue_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_sel", sel, 0);
    chk("rst_level", level, 0);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;

    // Single issue then backpressure: state after each edge
    row(1, 5, 3, 0, 1,  0, 0, 0, 0, 0+1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1,  1, 5, 3, 0, 0, 1, 8, 0, 0);
    row(0, 0, 0, 0, 1,  0, 5, 3, 0, 0, 1, 0, 0, 0);
    row(1, 10, 7, 0, 0, 0, 5, 3, 0, 1, 1, 0, 0, 0);
    row(1, 9, 4, 1, 0,  0, 5, 3, 0, 2, 1, 0, 0, 0);
    row(1, 5, 5, 1, 0,  0, 5, 3, 0, 3, 1, 0, 0, 0);
    row(1, 12, 10, 2, 0, 0, 5, 3, 0, 4, 0, 0, 0, 0);
    row(1, 12, 10, 3, 0, 0, 5, 3, 0, 4, 0, 0, 0, 0);
    row(1, 12, 10, 3, 1, 1, 10, 7, 0, 3, 1, 1, 1, 0);
    row(1, 12, 10, 3, 1, 1, 9, 4, 1, 3, 1, 5, 0, 0);
    row(0, 0, 0, 0, 1,  1, 5, 5, 1, 2, 1, 0, 0, 1);
    row(0, 0, 0, 0, 1,  1, 12, 10, 2, 1, 1, 8, 0, 0);
    row(0, 0, 0, 0, 1,  1, 12, 10, 3, 0, 1, 14, 0, 0);
    row(0, 0, 0, 0, 1,  0, 12, 10, 3, 0, 1, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.iv, v.ia, v.ib, v.is, v.ir, v.fl);
      tick();
      chk($sformatf("r%0d_iv", i), issue_valid, v.ev);
      chk($sformatf("r%0d_abs", i), {a, b, sel}, {v.ea, v.eb, v.es});
      chk($sformatf("r%0d_level", i), level, v.el);
      chk($sformatf("r%0d_rdy", i), in_ready, v.erdy);
      if (v.ev)
        chk($sformatf("r%0d_alu", i), {result, carry, zero},
            {v.eres, v.ec, v.ez});
    end

    // Wrap-around: 10 back-to-back pushes, issue_ready held high
    issued = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin
        drive(1, i, 15 - i, i % 4, 1, 0);
        exp_q.push_back((i << 6) | ((15 - i) << 2) | (i % 4));
      end else begin
        drive(0, 0, 0, 0, 1, 0);
      end
      tick();
      if (level > 2) chk("wrap_level_max", level, 2);
      if (issue_valid) begin
        if (exp_q.size() == 0) chk("wrap_extra_issue", 1, 0);
        else chk($sformatf("wrap_cmd%0d", issued),
                 {a, b, sel}, exp_q.pop_front());
        issued++;
      end
    end
    chk("wrap_count", issued, 10);
    chk("wrap_level_end", level, 0);

    // Flush with 3 queued and a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, i + 2, 0, 0, 0);
      tick();
    end
    chk("fl_pre_level", level, 3);
    drive(1, 1, 1, 3, 1, 1);
    tick();
    chk("fl_level", level, 0);
    chk("fl_iv", issue_valid, 0);
    chk("fl_rdy", in_ready, 1);
    issued = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      tick();
      if (issue_valid) issued++;
    end
    chk("fl_no_issue", issued, 0);
    chk("fl_level_after", level, 0);

    // Reset while level=3 and issue_valid=1
    for (int i = 0; i < 4; i++) begin
      drive(1, 7, i, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("mr_pre_iv", issue_valid, 1);
    chk("mr_pre_level", level, 3);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_iv", issue_valid, 0);
    chk("mr_level", level, 0);
    chk("mr_a", a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 0, 1, 0);
    tick();
    chk("mr_resume_level", level, 1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("mr_resume_iv", issue_valid, 1);
    chk("mr_resume_alu", {a, b, result, carry}, {4'd1, 4'd1, 4'd2, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
